melody_sequencer: RTL and testbench

- Autonomous note scheduler that drives the piano tone datapath in place of the switches.
- On `start`, it steps through a song stored in an external synchronous ROM, one entry per note.
- For each entry it presents a one-hot note select, a 2-bit volume level and a gate for the entry's duration, then inserts a short silent gap.
- It sits between the user-key logic and the tone generator/DAC serializer, on the `CLOCK_27` domain.

---
 rtl/piano_pkg.sv | 41 ++++
 rtl/melody_sequencer_if.sv | 33 +++
 rtl/tick_gen.sv | 29 ++
 rtl/melody_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: definitions shared by the piano tone datapath and the melody sequencer.
//   - Note index constants NOTE_DO..NOTE_DO1 (0..7).
//   - Layout of the 14-bit song ROM entry (rom_entry_t).
//   - Sequencer state encoding (seq_state_t plus St* constants).
//   - note_to_onehot(): note index to one-hot tone select.
package piano_pkg;

  localparam logic [2:0] NOTE_DO  = 3'd0;
  localparam logic [2:0] NOTE_RE  = 3'd1;
  localparam logic [2:0] NOTE_MI  = 3'd2;
  localparam logic [2:0] NOTE_FA  = 3'd3;
  localparam logic [2:0] NOTE_SOL = 3'd4;
  localparam logic [2:0] NOTE_LA  = 3'd5;
  localparam logic [2:0] NOTE_SI  = 3'd6;
  localparam logic [2:0] NOTE_DO1 = 3'd7;

  localparam int unsigned ENTRY_W = 14;

  // ROM entry: [13] rest, [12:10] note, [9:8] volume, [7:0] duration in ticks.
  // A duration of 0 marks the end of the song.
  typedef struct packed {
    logic       rest;
    logic [2:0] note;
    logic [1:0] vol;
    logic [7:0] dur;
  } rom_entry_t;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t StIdle   = 3'd0;
  localparam seq_state_t StFetch  = 3'd1;
  localparam seq_state_t StDecode = 3'd2;
  localparam seq_state_t StPlay   = 3'd3;
  localparam seq_state_t StGap    = 3'd4;
  localparam seq_state_t StFinish = 3'd5;

  function automatic logic [7:0] note_to_onehot(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: control, song ROM and voice signals of the melody sequencer.
//   start, stop          : one-cycle control pulses
//   rom_addr / rom_data  : synchronous ROM port, data valid one cycle after address
//   note_onehot, volume,
//   gate                 : voice controls for the tone generator / DAC path
//   busy, done           : status
// Modports: master = sequencer side, slave = song ROM / controller side.
interface melody_sequencer_if
  import piano_pkg::*;
#(
  parameter int unsigned SONG_LEN = 16,
  parameter int unsigned AW       = $clog2(SONG_LEN)
) ();
  logic          start;
  logic          stop;
  logic [AW-1:0] rom_addr;
  rom_entry_t    rom_data;
  logic [7:0]    note_onehot;
  logic [1:0]    volume;
  logic          gate;
  logic          busy;
  logic          done;

  modport master (
    input  start, stop, rom_data,
    output rom_addr, note_onehot, volume, gate, busy, done
  );

  modport slave (
    output start, stop, rom_data,
    input  rom_addr, note_onehot, volume, gate, busy, done
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: clearable prescaler; tick is high for one cycle every TICK_DIV clocks.
//   CLOCK_27 : clock
//   RESET    : asynchronous active-high reset
//   clear    : restart the count at 0 on the next clock
//   tick     : high while the count sits at TICK_DIV-1
module tick_gen #(
  parameter int unsigned TICK_DIV = 27000
) (
  input  logic CLOCK_27,
  input  logic RESET,
  input  logic clear,
  output logic tick
);
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge CLOCK_27 or posedge RESET) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a song ROM and drives the piano voice controls.
//   CLOCK_27 : system clock
//   RESET    : asynchronous active-high reset
//   bus      : melody_sequencer_if.master (start/stop, ROM port, voice outputs, busy/done)
// Build option: define MELODY_LOOP_EN to restart from entry 0 after every song end
// instead of returning to idle.
module melody_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 27000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned SONG_LEN  = 16,
  parameter int unsigned GAP_TICKS = 20
) (
  input logic                CLOCK_27,
  input logic                RESET,
  melody_sequencer_if.master bus
);
  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned AW       = $clog2(SONG_LEN);
  localparam int unsigned GW       = $clog2(GAP_TICKS + 2);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    dur_q, dur_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          rest_q, rest_d;
  logic [2:0]    tone_q, tone_d;
  logic [1:0]    level_q, level_d;

  logic [7:0]    onehot_q, onehot_d;
  logic [1:0]    volume_q, volume_d;
  logic          gate_q, gate_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tick;
  logic          tick_clear;
  rom_entry_t    rom_word;

  assign rom_word = bus.rom_data;

  // Every state change restarts the prescaler, so PLAY and GAP always begin on a
  // fresh TICK_DIV period; idle keeps it parked at 0.
  assign tick_clear = (state_d != state_q) || (state_q == StIdle);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLOCK_27(CLOCK_27),
    .RESET   (RESET),
    .clear   (tick_clear),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    rest_d  = rest_q;
    tone_d  = tone_q;
    level_d = level_q;

    if (bus.stop) begin
      state_d = StIdle;
      addr_d  = '0;
      dur_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = StFetch;
            addr_d  = '0;
          end
        end
        StFetch: state_d = StDecode;
        StDecode: begin
          rest_d  = rom_word.rest;
          tone_d  = rom_word.note;
          level_d = rom_word.vol;
          if (rom_word.dur == 8'd0) begin
            state_d = StFinish;
          end else begin
            state_d = StPlay;
            dur_d   = rom_word.dur;
          end
        end
        StPlay: begin
          if (tick) begin
            if (dur_q <= 8'd1) begin
              state_d = StGap;
              gap_d   = GW'(GAP_TICKS);
            end else begin
              dur_d = dur_q - 8'd1;
            end
          end
        end
        StGap: begin
          if (tick) begin
            if (gap_q <= GW'(1)) begin
              if (addr_q == AW'(SONG_LEN - 1)) begin
                state_d = StFinish;
              end else begin
                state_d = StFetch;
                addr_d  = addr_q + AW'(1);
              end
            end else begin
              gap_d = gap_q - GW'(1);
            end
          end
        end
        StFinish: begin
`ifdef MELODY_LOOP_EN
          state_d = StFetch;
          addr_d  = '0;
`else
          // rom_addr is left on the last entry; start reloads it to 0.
          state_d = StIdle;
`endif
        end
        default: begin
          state_d = StIdle;
          addr_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    onehot_d = '0;
    volume_d = '0;
    gate_d   = 1'b0;
    if (state_d == StPlay) begin
      volume_d = level_d;
      if (!rest_d) begin
        onehot_d = note_to_onehot(tone_d);
        gate_d   = 1'b1;
      end
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StFinish);
  end

  always_ff @(posedge CLOCK_27 or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      dur_q    <= '0;
      gap_q    <= '0;
      rest_q   <= 1'b0;
      tone_q   <= '0;
      level_q  <= '0;
      onehot_q <= '0;
      volume_q <= '0;
      gate_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
      rest_q   <= rest_d;
      tone_q   <= tone_d;
      level_q  <= level_d;
      onehot_q <= onehot_d;
      volume_q <= volume_d;
      gate_q   <= gate_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.rom_addr    = addr_q;
  assign bus.note_onehot = onehot_q;
  assign bus.volume      = volume_q;
  assign bus.gate        = gate_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed bench for melody_sequencer with TICK_DIV = 10,
// GAP_TICKS = 1, SONG_LEN = 4. Cycle n is the cycle after the n-th rising edge
// counted from the edge that samples start (cycle 0). Outputs are sampled 1 ns
// after each rising edge.
module tb_melody_sequencer;
  import piano_pkg::*;

  localparam int unsigned SONG_LEN = 4;

  logic CLOCK_27 = 1'b0;
  logic RESET;
  logic [13:0] rom [SONG_LEN];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  melody_sequencer_if #(.SONG_LEN(SONG_LEN)) bus ();

  melody_sequencer #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .SONG_LEN (SONG_LEN),
    .GAP_TICKS(1)
  ) dut (
    .CLOCK_27(CLOCK_27),
    .RESET   (RESET),
    .bus     (bus)
  );

  always #5 CLOCK_27 = ~CLOCK_27;

  // Synchronous song ROM.
  always @(posedge CLOCK_27) bus.rom_data <= rom[bus.rom_addr];

  task automatic clk_step();
    @(posedge CLOCK_27);
    #1;
    cyc++;
  endtask

  task automatic start_song();
    cyc = 0;
    bus.start = 1'b1;
    clk_step();
    bus.start = 1'b0;
  endtask

  task automatic stop_song();
    bus.stop = 1'b1;
    clk_step();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < SONG_LEN; i++) rom[i] = '0;
    #2; // no clock edge yet: reset values come from the asynchronous reset
    n_checks++; if (bus.rom_addr !== 2'd0) $display("FAIL reset rom_addr got %h want 0", bus.rom_addr); else n_pass++;
    n_checks++; if (bus.note_onehot !== 8'h00) $display("FAIL reset note_onehot got %h want 00", bus.note_onehot); else n_pass++;
    n_checks++; if (bus.volume !== 2'd0) $display("FAIL reset volume got %h want 0", bus.volume); else n_pass++;
    n_checks++; if (bus.gate !== 1'b0) $display("FAIL reset gate got %b want 0", bus.gate); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset done got %b want 0", bus.done); else n_pass++;
    clk_step();
    RESET = 1'b0;
    clk_step();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_release busy got %b want 0", bus.busy); else n_pass++;
  endtask

  // MI, volume 1, 3 ticks: FETCH 1, DECODE 2, PLAY 3..32, GAP 33..42,
  // FETCH 43, DECODE 44 (end marker), FINISH 45, idle from 46.
  task automatic test_single_note();
    logic [12:0] obs, exp;
    logic gate_e;
    rom[0] = {1'b0, NOTE_MI, 2'd1, 8'd3};
    rom[1] = {1'b0, NOTE_DO, 2'd0, 8'd0};
    start_song();
    while (cyc <= 47) begin
      gate_e = (cyc >= 3 && cyc <= 32);
      exp = {gate_e ? 8'h04 : 8'h00, gate_e ? 2'd1 : 2'd0, gate_e, 1'(cyc <= 45), 1'(cyc == 45)};
      obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done};
      n_checks++;
      if (obs !== exp) $display("FAIL single_note cyc=%0d got %h want %h", cyc, obs, exp);
      else n_pass++;
      clk_step();
    end
  endtask

  // Rest (vol 2, 2 ticks) PLAY 3..22, GAP 23..32; DO vol 3 1 tick PLAY 35..44,
  // GAP 45..54; FETCH 55, DECODE 56, FINISH 57.
  task automatic test_rest();
    logic [12:0] obs, exp;
    rom[0] = {1'b1, NOTE_SOL, 2'd2, 8'd2};
    rom[1] = {1'b0, NOTE_DO, 2'd3, 8'd1};
    rom[2] = '0;
    rom[3] = '0;
    start_song();
    while (cyc <= 58) begin
      exp = {8'h00, 2'd0, 1'b0, 1'(cyc <= 57), 1'(cyc == 57)};
      if (cyc >= 3 && cyc <= 22) exp[4:3] = 2'd2;
      if (cyc >= 35 && cyc <= 44) exp[12:2] = {8'h01, 2'd3, 1'b1};
      obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done};
      n_checks++;
      if (obs !== exp) $display("FAIL rest cyc=%0d got %h want %h", cyc, obs, exp);
      else n_pass++;
      clk_step();
    end
  endtask

  // Four 1-tick notes, 22 cycles each; after the 4th GAP (ends 88) FINISH at 89.
  task automatic test_full_song();
    logic [14:0] obs, exp;
    logic [7:0] one = 8'h01;
    int k, ph;
    logic play;
    for (int i = 0; i < 4; i++) rom[i] = {1'b0, 3'(i), 2'(i), 8'd1};
    start_song();
    while (cyc <= 90) begin
      k  = (cyc - 1) / 22;
      ph = (cyc - 1) % 22;
      play = (cyc <= 88) && (ph >= 2) && (ph <= 11);
      exp = {play ? (one << k) : 8'h00, play ? 2'(k) : 2'd0, play,
             1'(cyc <= 89), 1'(cyc == 89), (k > 3) ? 2'd3 : 2'(k)};
      obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done, bus.rom_addr};
      n_checks++;
      if (obs !== exp) $display("FAIL full_song cyc=%0d got %h want %h", cyc, obs, exp);
      else n_pass++;
      clk_step();
    end
  endtask

  task automatic test_stop();
    logic [14:0] obs;
    logic bad;
    rom[0] = {1'b0, NOTE_LA, 2'd3, 8'd1};
    rom[1] = {1'b0, NOTE_SI, 2'd2, 8'd1};
    rom[2] = '0;
    start_song();
    while (cyc < 10) clk_step();
    obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done, bus.rom_addr};
    n_checks++; if (obs !== {8'h20, 2'd3, 3'b110, 2'd0}) $display("FAIL stop_pre cyc=10 got %h want %h", obs, {8'h20, 2'd3, 3'b110, 2'd0}); else n_pass++;
    stop_song();
    obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done, bus.rom_addr};
    n_checks++; if (obs !== 15'd0) $display("FAIL stop_note0 cyc=11 got %h want 0", obs); else n_pass++;
    // Second entry plays 25..34 with rom_addr = 1.
    start_song();
    while (cyc < 30) clk_step();
    obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done, bus.rom_addr};
    n_checks++; if (obs !== {8'h40, 2'd2, 3'b110, 2'd1}) $display("FAIL stop_pre cyc=30 got %h want %h", obs, {8'h40, 2'd2, 3'b110, 2'd1}); else n_pass++;
    stop_song();
    obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done, bus.rom_addr};
    n_checks++; if (obs !== 15'd0) $display("FAIL stop_note1 cyc=31 got %h want 0", obs); else n_pass++;
    bad = 1'b0;
    repeat (40) begin
      clk_step();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL stop_idle busy_or_done_seen got %b want 0", bad); else n_pass++;
    start_song();
    while (cyc < 3) clk_step();
    obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done, bus.rom_addr};
    n_checks++; if (obs !== {8'h20, 2'd3, 3'b110, 2'd0}) $display("FAIL stop_replay cyc=3 got %h want %h", obs, {8'h20, 2'd3, 3'b110, 2'd0}); else n_pass++;
    stop_song();
  endtask

  // Extra start pulses at cycles 5 and 25 must not disturb a 2-tick RE note:
  // PLAY 3..22, GAP 23..32, FETCH 33 (addr 1), DECODE 34, FINISH 35.
  task automatic test_collisions();
    logic [14:0] obs, exp;
    logic gate_e;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    clk_step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL start_stop_idle busy got %b want 0", bus.busy); else n_pass++;
    repeat (5) clk_step();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL start_stop_later busy got %b want 0", bus.busy); else n_pass++;
    rom[0] = {1'b0, NOTE_RE, 2'd2, 8'd2};
    rom[1] = '0;
    start_song();
    while (cyc <= 36) begin
      gate_e = (cyc >= 3 && cyc <= 22);
      exp = {gate_e ? 8'h02 : 8'h00, gate_e ? 2'd2 : 2'd0, gate_e,
             1'(cyc <= 35), 1'(cyc == 35), (cyc >= 33) ? 2'd1 : 2'd0};
      obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done, bus.rom_addr};
      n_checks++;
      if (obs !== exp) $display("FAIL start_busy cyc=%0d got %h want %h", cyc, obs, exp);
      else n_pass++;
      bus.start = (cyc == 5 || cyc == 25);
      clk_step();
      bus.start = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] obs;
    rom[0] = {1'b0, NOTE_FA, 2'd1, 8'd3};
    rom[1] = '0;
    start_song();
    while (cyc < 10) clk_step();
    n_checks++; if (bus.note_onehot !== 8'h08) $display("FAIL areset_pre note_onehot got %h want 08", bus.note_onehot); else n_pass++;
    #2;
    RESET = 1'b1;
    #1; // still between clock edges
    obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done, bus.rom_addr};
    n_checks++; if (obs !== 15'd0) $display("FAIL areset_async got %h want 0", obs); else n_pass++;
    #1;
    RESET = 1'b0;
    clk_step();
    clk_step();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL areset_idle busy got %b want 0", bus.busy); else n_pass++;
  endtask

`ifdef MELODY_LOOP_EN
  // SOL 1 tick PLAY 3..12, GAP 13..22, FETCH 23 (addr 1), DECODE 24, FINISH 25,
  // FETCH 26 (addr 0), DECODE 27, PLAY 28..37.
  task automatic test_loop();
    logic [14:0] obs, exp;
    logic gate_e;
    rom[0] = {1'b0, NOTE_SOL, 2'd1, 8'd1};
    rom[1] = '0;
    start_song();
    while (cyc <= 37) begin
      gate_e = (cyc >= 3 && cyc <= 12) || (cyc >= 28);
      exp = {gate_e ? 8'h10 : 8'h00, gate_e ? 2'd1 : 2'd0, gate_e, 1'b1,
             1'(cyc == 25), (cyc >= 23 && cyc <= 25) ? 2'd1 : 2'd0};
      obs = {bus.note_onehot, bus.volume, bus.gate, bus.busy, bus.done, bus.rom_addr};
      n_checks++;
      if (obs !== exp) $display("FAIL loop cyc=%0d got %h want %h", cyc, obs, exp);
      else n_pass++;
      clk_step();
    end
    stop_song();
  endtask
`endif

  initial begin
    test_reset();
`ifdef MELODY_LOOP_EN
    test_loop();
    test_stop();
    test_async_reset();
`else
    test_single_note();
    test_rest();
    test_full_song();
    test_stop();
    test_collisions();
    test_async_reset();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
